// File: rtl/stopwatch_ctrl.sv
// Button conditioning, clock-mode sequencing and stopwatch start/pause/clear FSM.
// Optional lap-freeze feature is enabled by defining STOPWATCH_LAP_EN.
module stopwatch_ctrl #(
  parameter int DB_CYCLES = 4
) (
  input  logic       wt_clk,
  input  logic       rst,
  input  logic [3:0] btn_raw,
  output logic [1:0] st,
  output logic [3:0] sw_btn,
  output logic       sw_running,
  output logic       lap_hold
);
`ifdef STOPWATCH_LAP_EN
  localparam int NB = 4;
`else
  localparam int NB = 3;
`endif
  localparam int GUARD = DB_CYCLES + 3;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_CLEAR} state_t;

  logic [NB-1:0] r_sync1, r_sync2, r_db, r_db_q, r_evt, w_rise;
  logic [7:0]    r_cnt [NB];
  logic [8:0]    r_gcnt;
  logic          w_armed;

  state_t        r_state, w_next;
  logic [1:0]    r_st;
  logic [3:0]    r_sw_btn, w_sw_btn;
  logic          r_running;
  logic          w_mode, w_act, w_clr, w_start;

  always_ff @(posedge wt_clk) begin
    if (rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_db    <= '0;
      r_db_q  <= '0;
      r_evt   <= '0;
      for (int i = 0; i < NB; i++) r_cnt[i] <= '0;
    end else begin
      r_sync1 <= btn_raw[NB-1:0];
      r_sync2 <= r_sync1;
      r_db_q  <= r_db;
      r_evt   <= w_rise;
      for (int i = 0; i < NB; i++) begin
        if (r_sync2[i] == r_db[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == 8'(DB_CYCLES - 1)) begin
          r_cnt[i] <= '0;
          r_db[i]  <= r_sync2[i];
        end else begin
          r_cnt[i] <= r_cnt[i] + 8'd1;
        end
      end
    end
  end

  // A button held through reset re-qualifies high inside this window; mask that edge.
  always_ff @(posedge wt_clk) begin
    if (rst)           r_gcnt <= '0;
    else if (!w_armed) r_gcnt <= r_gcnt + 9'd1;
  end

  assign w_armed = (r_gcnt == 9'(GUARD));
  assign w_rise  = r_db & ~r_db_q & {NB{w_armed}};

  assign w_mode  = r_evt[0];
  assign w_act   = !w_mode && (r_st == 2'b01);
  assign w_clr   = w_act & r_evt[1];
  assign w_start = w_act & r_evt[2];

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_clr) w_next = S_CLEAR; else if (w_start) w_next = S_RUN;
      S_RUN:   if (w_start) w_next = S_PAUSE;
      S_PAUSE: if (w_clr) w_next = S_CLEAR; else if (w_start) w_next = S_RUN;
      S_CLEAR: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    w_sw_btn = 4'b0000;
    case (w_next)
      S_RUN:   w_sw_btn = 4'b1000;
      S_PAUSE: w_sw_btn = 4'b0100;
      S_CLEAR: w_sw_btn = 4'b0010;
      default: w_sw_btn = 4'b0000;
    endcase
  end

  always_ff @(posedge wt_clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_st      <= 2'b00;
      r_sw_btn  <= 4'b0000;
      r_running <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_st      <= r_st + {1'b0, w_mode};
      r_sw_btn  <= w_sw_btn;
      r_running <= (w_next == S_RUN);
    end
  end

  assign st         = r_st;
  assign sw_btn     = r_sw_btn;
  assign sw_running = r_running;

`ifdef STOPWATCH_LAP_EN
  logic r_lap, w_lap_next, w_lap;

  assign w_lap = w_act & r_evt[3];

  always_comb begin
    w_lap_next = r_lap;
    if (w_next != S_RUN)                 w_lap_next = 1'b0;
    else if (r_state == S_RUN && w_lap)  w_lap_next = ~r_lap;
  end

  always_ff @(posedge wt_clk) begin
    if (rst) r_lap <= 1'b0;
    else     r_lap <= w_lap_next;
  end

  assign lap_hold = r_lap;
`else
  logic w_unused_lap;
  assign w_unused_lap = btn_raw[3];
  assign lap_hold     = 1'b0;
`endif

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: directed and random button sequences against an
// event-level model (a clean press lands DB+4 edges after it is driven).
module tb_stopwatch_ctrl;
  localparam int DB  = 4;
  localparam int LAT = DB + 4;

  logic       wt_clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] btn_raw = 4'b0000;
  logic [1:0] st;
  logic [3:0] sw_btn;
  logic       sw_running, lap_hold;

  stopwatch_ctrl #(.DB_CYCLES(DB)) dut (
    .wt_clk(wt_clk), .rst(rst), .btn_raw(btn_raw),
    .st(st), .sw_btn(sw_btn), .sw_running(sw_running), .lap_hold(lap_hold)
  );

  always #5 wt_clk = ~wt_clk;

  typedef struct {
    logic [3:0] v;
    bit         q;
    bit         r;
    int         n;
  } step_t;

  int         cyc = 0, n_chk = 0, n_fail = 0;
  logic [3:0] sched [int];
  int         m_st = 0, m_fs = 0;  // m_fs: 0 idle, 1 run, 2 pause, 3 clear
  bit         m_lap = 1'b0;

  function automatic logic [7:0] exp_vec();
    logic [3:0] b;
    logic [1:0] s;
    case (m_fs)
      1:       b = 4'b1000;
      2:       b = 4'b0100;
      3:       b = 4'b0010;
      default: b = 4'b0000;
    endcase
    s = m_st[1:0];
    return {s, b, (m_fs == 1), m_lap};
  endfunction

  function automatic logic [7:0] obs();
    return {st, sw_btn, sw_running, lap_hold};
  endfunction

  task automatic model_edge();
    logic [3:0] e;
    int prev;
    bit act;
    e = 4'b0000;
    if (sched.exists(cyc)) begin
      e = sched[cyc];
      sched.delete(cyc);
    end
    prev = m_fs;
    act  = !e[0] && (m_st == 1);
    if (e[0]) m_st = (m_st + 1) % 4;
    case (prev)
      0: if (act && e[1]) m_fs = 3; else if (act && e[2]) m_fs = 1;
      1: if (act && e[2]) m_fs = 2;
      2: if (act && e[1]) m_fs = 3; else if (act && e[2]) m_fs = 1;
      default: m_fs = 0;
    endcase
`ifdef STOPWATCH_LAP_EN
    if (m_fs != 1) m_lap = 1'b0;
    else if (prev == 1 && act && e[3]) m_lap = !m_lap;
`endif
  endtask

  task automatic tick();
    @(posedge wt_clk);
    cyc++;
    if (rst) begin
      m_st = 0; m_fs = 0; m_lap = 1'b0;
      sched.delete();
    end else begin
      model_edge();
    end
    #1;
  endtask

  // Drive buttons; q marks a clean (debounce-qualifying) press to be scheduled.
  task automatic drive(input logic [3:0] v, input bit q);
    for (int b = 0; b < 4; b++) begin
      if (q && v[b] && !btn_raw[b]) begin
        if (sched.exists(cyc + LAT)) sched[cyc + LAT] = sched[cyc + LAT] | (4'b0001 << b);
        else                         sched[cyc + LAT] = 4'b0001 << b;
      end
    end
    btn_raw = v;
  endtask

  function automatic void add_press(ref step_t s[$], input logic [3:0] v, input int hold, input int gap);
    s.push_back('{v, 1'b1, 1'b0, hold});
    s.push_back('{4'b0000, 1'b0, 1'b0, gap});
  endfunction

  task automatic test_reset();
    step_t s[$];
    s.push_back('{4'b0000, 1'b0, 1'b1, 3});
    s.push_back('{4'b0000, 1'b0, 1'b0, 12});
    foreach (s[i]) begin
      drive(s[i].v, s[i].q); rst = s[i].r;
      for (int k = 0; k < s[i].n; k++) begin
        tick(); n_chk++;
        if (obs() !== exp_vec()) begin
          n_fail++; $display("FAIL reset cyc=%0d got=%b exp=%b", cyc, obs(), exp_vec());
        end
      end
    end
  endtask

  task automatic test_mode();
    step_t s[$];
    for (int i = 0; i < 4; i++) add_press(s, 4'b0001, 10, 10);
    foreach (s[i]) begin
      drive(s[i].v, s[i].q); rst = s[i].r;
      for (int k = 0; k < s[i].n; k++) begin
        tick(); n_chk++;
        if (obs() !== exp_vec()) begin
          n_fail++; $display("FAIL mode cyc=%0d got=%b exp=%b", cyc, obs(), exp_vec());
        end
      end
    end
  endtask

  task automatic test_stopwatch();
    step_t s[$];
    add_press(s, 4'b0001, 10, 10);  // st -> 01
    add_press(s, 4'b0100, 10, 10);  // start -> RUN
    add_press(s, 4'b0100, 10, 10);  // start -> PAUSE
    add_press(s, 4'b0010, 10, 10);  // clear -> CLEAR -> IDLE
    foreach (s[i]) begin
      drive(s[i].v, s[i].q); rst = s[i].r;
      for (int k = 0; k < s[i].n; k++) begin
        tick(); n_chk++;
        if (obs() !== exp_vec()) begin
          n_fail++; $display("FAIL stopwatch cyc=%0d got=%b exp=%b", cyc, obs(), exp_vec());
        end
      end
    end
  endtask

  task automatic test_run_ignore();
    step_t s[$];
    add_press(s, 4'b0100, 10, 10);                // RUN
    add_press(s, 4'b0010, 10, 10);                // clear ignored in RUN
    s.push_back('{4'b0100, 1'b0, 1'b0, DB - 1});  // glitch on start
    s.push_back('{4'b0000, 1'b0, 1'b0, 15});
    foreach (s[i]) begin
      drive(s[i].v, s[i].q); rst = s[i].r;
      for (int k = 0; k < s[i].n; k++) begin
        tick(); n_chk++;
        if (obs() !== exp_vec()) begin
          n_fail++; $display("FAIL run_ignore cyc=%0d got=%b exp=%b", cyc, obs(), exp_vec());
        end
      end
    end
  endtask

  task automatic test_simultaneous();
    step_t s[$];
    add_press(s, 4'b0100, 10, 10);  // RUN -> PAUSE
    add_press(s, 4'b0010, 10, 10);  // PAUSE -> CLEAR -> IDLE
    add_press(s, 4'b0101, 10, 10);  // start+mode: st 10, FSM stays IDLE
    for (int i = 0; i < 3; i++) add_press(s, 4'b0001, 8, 8);  // back to 01
    add_press(s, 4'b0100, 10, 10);  // RUN
    add_press(s, 4'b0110, 10, 10);  // start+clear in RUN: start wins -> PAUSE
    add_press(s, 4'b0110, 10, 10);  // start+clear in PAUSE: clear wins
    foreach (s[i]) begin
      drive(s[i].v, s[i].q); rst = s[i].r;
      for (int k = 0; k < s[i].n; k++) begin
        tick(); n_chk++;
        if (obs() !== exp_vec()) begin
          n_fail++; $display("FAIL simultaneous cyc=%0d got=%b exp=%b", cyc, obs(), exp_vec());
        end
      end
    end
  endtask

  task automatic test_lap_reset();
    step_t s[$];
    add_press(s, 4'b0100, 10, 10);  // RUN
    add_press(s, 4'b1000, 10, 10);  // lap toggles
    add_press(s, 4'b1000, 10, 10);
    add_press(s, 4'b1000, 10, 10);
    add_press(s, 4'b0100, 10, 10);  // PAUSE, lap cleared
    add_press(s, 4'b1000, 10, 10);  // ignored in PAUSE
    add_press(s, 4'b0100, 10, 10);  // RUN
    add_press(s, 4'b1000, 10, 10);
    s.push_back('{4'b0000, 1'b0, 1'b1, 1});  // reset during RUN
    s.push_back('{4'b0000, 1'b0, 1'b0, 12});
    foreach (s[i]) begin
      drive(s[i].v, s[i].q); rst = s[i].r;
      for (int k = 0; k < s[i].n; k++) begin
        tick(); n_chk++;
        if (obs() !== exp_vec()) begin
          n_fail++; $display("FAIL lap_reset cyc=%0d got=%b exp=%b", cyc, obs(), exp_vec());
        end
      end
    end
  endtask

  task automatic test_held_through_reset();
    step_t s[$];
    s.push_back('{4'b0001, 1'b1, 1'b0, 3});   // mode press cut short by reset
    s.push_back('{4'b0001, 1'b0, 1'b1, 2});
    s.push_back('{4'b0001, 1'b0, 1'b0, 20});  // still held: no event
    s.push_back('{4'b0000, 1'b0, 1'b0, 10});
    add_press(s, 4'b0001, 10, 10);            // fresh press counts
    foreach (s[i]) begin
      drive(s[i].v, s[i].q); rst = s[i].r;
      for (int k = 0; k < s[i].n; k++) begin
        tick(); n_chk++;
        if (obs() !== exp_vec()) begin
          n_fail++; $display("FAIL held_reset cyc=%0d got=%b exp=%b", cyc, obs(), exp_vec());
        end
      end
    end
  endtask

  task automatic test_random();
    step_t s[$];
    for (int i = 0; i < 90; i++) begin
      int kind, hold, gap;
      logic [3:0] m;
      kind = $urandom_range(0, 10);
      hold = $urandom_range(6, 12);
      gap  = $urandom_range(6, 12);
      case (kind)
        0, 1:    add_press(s, 4'b0001, hold, gap);
        2, 3, 4: add_press(s, 4'b0100, hold, gap);
        5, 6:    add_press(s, 4'b0010, hold, gap);
        7:       add_press(s, 4'b1000, hold, gap);
        8: begin
          m = 4'($urandom_range(1, 15));
          add_press(s, m, hold, gap);
        end
        9: begin
          m = 4'b0001 << $urandom_range(0, 3);
          s.push_back('{m, 1'b0, 1'b0, $urandom_range(1, DB - 1)});
          s.push_back('{4'b0000, 1'b0, 1'b0, gap});
        end
        default: begin
          s.push_back('{4'b0000, 1'b0, 1'b1, $urandom_range(1, 2)});
          s.push_back('{4'b0000, 1'b0, 1'b0, 10});
        end
      endcase
    end
    foreach (s[i]) begin
      drive(s[i].v, s[i].q); rst = s[i].r;
      for (int k = 0; k < s[i].n; k++) begin
        tick(); n_chk++;
        if (obs() !== exp_vec()) begin
          n_fail++; $display("FAIL random cyc=%0d got=%b exp=%b", cyc, obs(), exp_vec());
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_mode();
    test_stopwatch();
    test_run_ignore();
    test_simultaneous();
    test_lap_reset();
    test_held_through_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
